// File: rtl/butterfly_feeder_if.sv
// Stream bundle for butterfly_feeder: sample input
// and butterfly operand output, both valid/ready.
interface butterfly_feeder_if;
  logic        InValid;
  logic [31:0] InData;
  logic        InReady;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] w;
  logic [2:0]  OutK;
  logic        OutLast;

  modport master (
    output InValid, InData, OutReady,
    input  InReady, OutValid, A, B, w,
    input  OutK, OutLast
  );

  modport slave (
    input  InValid, InData, OutReady,
    output InReady, OutValid, A, B, w,
    output OutK, OutLast
  );
endinterface

// File: rtl/butterfly_feeder.sv
// Radix-2 DIF butterfly input stage: buffers half a
// 16-point frame and pairs x[k] with x[k+8] and W16^k.
module butterfly_feeder (
  input logic Clk,
  input logic Rst,
  butterfly_feeder_if.slave io
);
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [8];
  logic [31:0] mem_d [8];
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] w_q, w_d;
  logic [2:0]  k_q, k_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        in_ready;
  logic        accept;
  logic        pair;
  logic [2:0]  k;

  function automatic logic [31:0] rom(
    input logic [2:0] idx
  );
    logic [31:0] r;
    unique case (idx)
      3'd0: r = 32'h04000000;
      3'd1: r = 32'h03B2FE78;
      3'd2: r = 32'h02D4FD2C;
      3'd3: r = 32'h0188FC4E;
      3'd4: r = 32'h0000FC00;
      3'd5: r = 32'hFE78FC4E;
      3'd6: r = 32'hFD2CFD2C;
      3'd7: r = 32'hFC4EFE78;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Input stalls only while an operand set is stuck.
  assign in_ready = ~(valid_q & ~io.OutReady);
  assign accept   = io.InValid & in_ready;
  assign pair     = accept & cnt_q[3];
  assign k        = cnt_q[2:0];

  always_comb begin
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    k_d     = k_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (accept) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (accept && !cnt_q[3]) begin
      mem_d[k] = io.InData;
    end
    if (pair) begin
      a_d     = mem_q[k];
      b_d     = io.InData;
      w_d     = rom(k);
      k_d     = k;
      last_d  = (k == 3'd7);
      valid_d = 1'b1;
    end else if (valid_q && io.OutReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      w_q     <= 32'd0;
      k_q     <= 3'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      k_q     <= k_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Half-frame buffer needs no reset; cnt gates its use.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign io.InReady  = in_ready;
  assign io.OutValid = valid_q;
  assign io.A        = a_q;
  assign io.B        = b_q;
  assign io.w        = w_q;
  assign io.OutK     = k_q;
  assign io.OutLast  = last_q;
endmodule
